// File: rtl/hazard_stall_scoreboard.sv
// Producer-side hazard scoreboard: tracks destination/Tnew per stage, stalls D when
// forwarding cannot cover a dependency, and owns the mult/div busy countdown.
module hazard_stall_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  output logic        stall,
  output logic        en_pc,
  output logic        en_D,
  output logic        flush_E,
  output logic        md_busy,
  output logic [1:0]  tnew_E,
  output logic [1:0]  tnew_M
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       special;
  logic       b_type, cal_r, cal_i, load, store, jr, jal, md, hilo, is_div, mf_hilo;
  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic [4:0] dest_D;
  logic [1:0] tnew_D;

  logic [4:0] dest_E, dest_M;
  logic [1:0] tnew_E_q, tnew_M_q;
  logic [1:0] is_md_E, is_md_M;
  logic [CNT_W-1:0] cnt;
  logic       data_haz;

  assign op      = instrD[31:26];
  assign rs      = instrD[25:21];
  assign rt      = instrD[20:16];
  assign rd      = instrD[15:11];
  assign funct   = instrD[5:0];
  assign special = (op == OP_SPECIAL);

  assign b_type  = (op == 6'h04) || (op == 6'h05);
  assign cal_r   = special && (funct[5:4] == 2'b10);
  assign cal_i   = (op[5:3] == 3'b001);
  assign load    = (op[5:3] == 3'b100);
  assign store   = (op[5:3] == 3'b101);
  assign jr      = special && (funct == 6'h08);
  assign jal     = (op == 6'h03);
  assign md      = special && (funct[5:2] == 4'b0110);
  assign is_div  = md && funct[1];
  assign hilo    = special && (funct[5:2] == 4'b0100);
  // mfhi (0x10) and mflo (0x12) write rd; mthi/mtlo do not
  assign mf_hilo = hilo && !funct[0];

  always_comb begin
    use_rs  = 1'b0;
    tuse_rs = 2'd0;
    use_rt  = 1'b0;
    tuse_rt = 2'd0;
    if (b_type || jr) begin
      use_rs = 1'b1; tuse_rs = 2'd0;
    end else if (cal_r || cal_i || load || store) begin
      use_rs = 1'b1; tuse_rs = 2'd1;
    end
    if (b_type) begin
      use_rt = 1'b1; tuse_rt = 2'd0;
    end else if (cal_r) begin
      use_rt = 1'b1; tuse_rt = 2'd1;
    end else if (store) begin
      use_rt = 1'b1; tuse_rt = 2'd2;
    end
  end

  always_comb begin
    dest_D = 5'd0;
    tnew_D = 2'd0;
    if (cal_r || mf_hilo) begin
      dest_D = rd; tnew_D = 2'd1;
    end else if (cal_i) begin
      dest_D = rt; tnew_D = 2'd1;
    end else if (load) begin
      dest_D = rt; tnew_D = 2'd2;
    end else if (jal) begin
      dest_D = 5'd31; tnew_D = 2'd0;
    end
  end

  function automatic logic haz(input logic [4:0] dst, input logic [1:0] tnew,
                               input logic [4:0] src, input logic used,
                               input logic [1:0] tuse);
    return (dst != 5'd0) && (dst == src) && used && (tuse < tnew);
  endfunction

  assign data_haz = haz(dest_E, tnew_E_q, rs, use_rs, tuse_rs)
                  | haz(dest_M, tnew_M_q, rs, use_rs, tuse_rs)
                  | haz(dest_E, tnew_E_q, rt, use_rt, tuse_rt)
                  | haz(dest_M, tnew_M_q, rt, use_rt, tuse_rt);

  assign md_busy = (cnt != '0) || is_md_E[1];
  assign stall   = data_haz || ((md || hilo) && md_busy);
  assign en_pc   = !stall;
  assign en_D    = !stall;
  assign flush_E = stall;
  assign tnew_E  = tnew_E_q;
  assign tnew_M  = tnew_M_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_E   <= '0;
      tnew_E_q <= '0;
      is_md_E  <= '0;
      dest_M   <= '0;
      tnew_M_q <= '0;
      is_md_M  <= '0;
    end else begin
      if (stall) begin
        dest_E   <= '0;
        tnew_E_q <= '0;
        is_md_E  <= '0;
      end else begin
        dest_E   <= dest_D;
        tnew_E_q <= tnew_D;
        is_md_E  <= {md, is_div};
      end
      dest_M   <= dest_E;
      tnew_M_q <= (tnew_E_q == 2'd0) ? 2'd0 : tnew_E_q - 2'd1;
      is_md_M  <= is_md_E;
    end
  end

  // D holds md ops while cnt != 0, so a load and a decrement never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (is_md_E[1])
      cnt <= is_md_E[0] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_scoreboard.sv
// Directed bench for hazard_stall_scoreboard: hand-encoded MIPS sequences with
// hand-derived stall, Tnew and md_busy expectations.
module tb_hazard_stall_scoreboard;

  logic        clk;
  logic        reset;
  logic [31:0] instrD;
  logic        stall, en_pc, en_D, flush_E, md_busy;
  logic [1:0]  tnew_E, tnew_M;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] LW1       = 32'h8C01_0000; // lw $1,0($0)
  localparam logic [31:0] LW0       = 32'h8C00_0000; // lw $0,0($0)
  localparam logic [31:0] ADDU_2_13 = 32'h0023_1021; // addu $2,$1,$3
  localparam logic [31:0] ADDU_1_23 = 32'h0043_0821; // addu $1,$2,$3
  localparam logic [31:0] BEQ_1_0   = 32'h1020_0000; // beq $1,$0
  localparam logic [31:0] BEQ_0_0   = 32'h1000_0000; // beq $0,$0
  localparam logic [31:0] SW_2_1    = 32'hAC22_0000; // sw $2,0($1)
  localparam logic [31:0] SW_1_2    = 32'hAC41_0000; // sw $1,0($2)
  localparam logic [31:0] MULT      = 32'h0085_0018; // mult $4,$5
  localparam logic [31:0] DIV       = 32'h0085_001A; // div $4,$5
  localparam logic [31:0] MFLO6     = 32'h0000_3012; // mflo $6
  localparam logic [31:0] JAL       = 32'h0C00_0000; // jal 0
  localparam logic [31:0] JR31      = 32'h03E0_0008; // jr $31

  hazard_stall_scoreboard dut (
    .clk(clk), .reset(reset), .instrD(instrD), .stall(stall), .en_pc(en_pc),
    .en_D(en_D), .flush_E(flush_E), .md_busy(md_busy), .tnew_E(tnew_E), .tnew_M(tnew_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    instrD = ins;
    #1;
  endtask

  task automatic drain();
    drive(NOP);
    repeat (3) tick();
  endtask

  // counts cycles with stall=1 while ins sits in D; bounded
  task automatic count_stall(input logic [31:0] ins, output int n);
    n = 0;
    drive(ins);
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    reset  = 1'b1;
    instrD = NOP;
    #2;
    chk("rst_stall",   32'(stall),   32'd0);
    chk("rst_en_pc",   32'(en_pc),   32'd1);
    chk("rst_en_D",    32'(en_D),    32'd1);
    chk("rst_flush",   32'(flush_E), 32'd0);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_tnew_E",  32'(tnew_E),  32'd0);
    chk("rst_tnew_M",  32'(tnew_M),  32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: lw -> addu, one stall cycle
    drive(LW1);
    chk("t1_lw_nostall", 32'(stall), 32'd0);
    tick();
    chk("t1_tnew_E", 32'(tnew_E), 32'd2);
    drive(ADDU_2_13);
    chk("t1_stall",   32'(stall),   32'd1);
    chk("t1_flush",   32'(flush_E), 32'd1);
    chk("t1_en_pc",   32'(en_pc),   32'd0);
    tick();
    chk("t1_tnew_M",   32'(tnew_M), 32'd1);
    chk("t1_bubble_E", 32'(tnew_E), 32'd0);
    chk("t1_release",  32'(stall),  32'd0);
    tick();
    chk("t1_addu_E", 32'(tnew_E), 32'd1);
    drain();

    // 2: lw -> beq, two stall cycles
    drive(LW1);
    tick();
    count_stall(BEQ_1_0, n);
    chk("t2_stall_cycles", 32'(n), 32'd2);
    drain();

    // 3: addu -> sw, no stall on either operand
    drive(ADDU_1_23);
    tick();
    drive(SW_2_1);
    chk("t3_sw_rs", 32'(stall), 32'd0);
    drive(SW_1_2);
    chk("t3_sw_rt", 32'(stall), 32'd0);
    drive(ADDU_2_13);
    chk("t3_addu_rs", 32'(stall), 32'd0);
    drive(BEQ_1_0);
    chk("t3_beq_E", 32'(stall), 32'd1);
    tick();
    chk("t3_beq_M", 32'(stall), 32'd0);
    drain();

    // 4: mult then mflo, 6 stall cycles; div, 11
    drive(MULT);
    tick();
    chk("t4_busy_E", 32'(md_busy), 32'd1);
    count_stall(MFLO6, n);
    chk("t4_mult_cycles", 32'(n), 32'd6);
    chk("t4_busy_off", 32'(md_busy), 32'd0);
    tick();
    chk("t4_mflo_E", 32'(tnew_E), 32'd1);
    drain();
    drive(DIV);
    tick();
    count_stall(MFLO6, n);
    chk("t4_div_cycles", 32'(n), 32'd11);
    drain();

    // 5: register 0 and jal/jr
    drive(LW0);
    tick();
    drive(BEQ_0_0);
    chk("t5_r0", 32'(stall), 32'd0);
    drain();
    drive(JAL);
    tick();
    chk("t5_jal_tnew", 32'(tnew_E), 32'd0);
    drive(JR31);
    chk("t5_jr_E", 32'(stall), 32'd0);
    drain();

    // 6: reset mid div countdown (cnt = 7)
    drive(DIV);
    tick();
    drive(NOP);
    repeat (4) tick();
    drive(MFLO6);
    chk("t6_pre_busy", 32'(md_busy), 32'd1);
    chk("t6_pre_stall", 32'(stall),  32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_busy", 32'(md_busy), 32'd0);
    chk("t6_stall", 32'(stall),  32'd0);
    chk("t6_en_D",  32'(en_D),   32'd1);
    reset = 1'b0;
    tick();
    chk("t6_mflo_E", 32'(tnew_E), 32'd1);
    chk("t6_no_busy", 32'(md_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
